tt_prog_mem_responder: RTL and testbench

- TinyTapeout user module acting as the external program memory for the 6-bit accumulator CPU.
- Receives the CPU's fetch address on its inputs and returns the 6-bit instruction/operand word on its outputs.
- 16 x 6-bit storage. Holds a reset-default program image and can be rewritten in-system through a bit-serial load port.
- Sits on the memory side of the CPU interface: CPU io_out[5:0] drives this block's address input, and this block's io_out[5:0] drives CPU io_in[7:2].

---
 rtl/tt_prog_mem_pkg.sv | 20 ++
 rtl/tt_prog_mem_loader.sv | 60 ++++++
 rtl/tt_prog_mem_responder.sv | 62 ++++++
 tb/tb_tt_prog_mem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tt_prog_mem_pkg.sv
// rtl/tt_prog_mem_pkg.sv - shared widths and reset-default program image
package tt_prog_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = 3;

  // Counter value of the sixth (last) serial bit of a word.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [DATA_W-1:0] DEFAULT_FILL = 6'h3C;

  localparam logic [DATA_W-1:0] DEFAULT_IMAGE [DEPTH] = '{
    6'd1, 6'd2, 6'd4, 6'd0, 6'd5, 6'd63, 6'd3, 6'd6,
    DEFAULT_FILL, DEFAULT_FILL, DEFAULT_FILL, DEFAULT_FILL,
    DEFAULT_FILL, DEFAULT_FILL, DEFAULT_FILL, DEFAULT_FILL
  };

endpackage

// File: rtl/tt_prog_mem_loader.sv
// rtl/tt_prog_mem_loader.sv - bit-serial word assembler with busy and write ack
module tt_prog_mem_loader
  import tt_prog_mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_le,
  input  logic              i_sd,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_ack
);

  // Only five bits are stored: the sixth bit of a word is taken straight
  // from the serial input on the commit edge.
  logic [DATA_W-2:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_ack;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_commit;

  // Commit on the last bit; dropping le mid-word abandons the partial word.
  always_comb begin
    w_commit  = 1'b0;
    w_cnt_nxt = r_cnt;
    if (!i_le) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == LAST_BIT) begin
      w_commit  = 1'b1;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Shift register, bit counter and registered status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_ack  <= w_commit;
      if (i_le) begin
        r_sr <= {r_sr[DATA_W-3:0], i_sd};
      end
    end
  end

  assign o_wr_en   = w_commit;
  assign o_wr_data = {r_sr, i_sd};
  assign o_busy    = r_busy;
  assign o_ack     = r_ack;

endmodule

// File: rtl/tt_prog_mem_responder.sv
// rtl/tt_prog_mem_responder.sv - 16x6 program memory for the accumulator CPU
module tt_prog_mem_responder
  import tt_prog_mem_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic              w_clk;
  logic              w_rst;
  logic [ADDR_W-1:0] w_addr;
  logic              w_le;
  logic              w_sd;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_busy;
  logic              w_ack;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Only the low four CPU address bits reach the pins, so 16..63 alias 0..15.
  assign w_clk  = io_in[0];
  assign w_rst  = io_in[1];
  assign w_addr = io_in[5:2];
  assign w_le   = io_in[6];
  assign w_sd   = io_in[7];

  tt_prog_mem_loader u_loader (
    .i_clk     (w_clk),
    .i_rst     (w_rst),
    .i_le      (w_le),
    .i_sd      (w_sd),
    .o_wr_en   (w_wr_en),
    .o_wr_data (w_wr_data),
    .o_busy    (w_busy),
    .o_ack     (w_ack)
  );

  // Storage: reset restores the full default image, discarding earlier loads.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DEFAULT_IMAGE[i];
      end
    end else if (w_wr_en) begin
      r_mem[w_addr] <= w_wr_data;
    end
  end

  // Read register: a same-address commit shows old data first, new data next edge.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[w_addr];
    end
  end

  assign io_out = {w_ack, w_busy, r_rdata};

endmodule

// File: tb/tb_tt_prog_mem_responder.sv
// tb/tb_tt_prog_mem_responder.sv - randomized and directed bench against a word-level memory model
module tb_tt_prog_mem_responder;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic       le;
  logic       sd;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_checks;
  int n_fail;

  // Reference model: whole-word memory plus a count of bits gathered so far.
  int         m_mem [16];
  int         m_word;
  int         m_bits;
  logic [5:0] m_rdata;
  logic       m_busy;
  logic       m_ack;

  assign io_in = {sd, le, addr, rst, clk};

  tt_prog_mem_responder dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    int img [8] = '{1, 2, 4, 0, 5, 63, 3, 6};
    for (int i = 0; i < 16; i++) m_mem[i] = (i < 8) ? img[i] : 60;
    m_word  = 0;
    m_bits  = 0;
    m_rdata = '0;
    m_busy  = 1'b0;
    m_ack   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model for that edge, compare all outputs.
  task automatic cyc(input logic [3:0] a, input logic l, input logic s, input string tag);
    addr = a;
    le   = l;
    sd   = s;
    @(posedge clk);
    m_rdata = 6'(m_mem[a]);
    m_ack   = 1'b0;
    if (l) begin
      m_word = ((m_word << 1) | int'(s)) % 64;
      m_bits++;
      if (m_bits == 6) begin
        m_mem[a] = m_word;
        m_bits   = 0;
        m_ack    = 1'b1;
      end
    end else begin
      m_bits = 0;
    end
    m_busy = (m_bits != 0);
    #1;
    chk(tag, io_out, {m_ack, m_busy, m_rdata});
  endtask

  task automatic load_word(input logic [3:0] a, input logic [5:0] val, input string tag);
    for (int i = 5; i >= 0; i--) cyc(a, 1'b1, val[i], tag);
  endtask

  // Two idle cycles at an address; afterwards io_out holds that word.
  task automatic rd(input logic [3:0] a, input string tag);
    cyc(a, 1'b0, 1'b0, tag);
    cyc(a, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int img [8] = '{1, 2, 4, 0, 5, 63, 3, 6};
    int acks;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    addr = '0;
    le   = 1'b0;
    sd   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", io_out, 8'h00);
    rst = 1'b0;

    // Default image sweep, one address per cycle, data one cycle later.
    for (int i = 0; i < 8; i++) begin
      cyc(4'(i), 1'b0, 1'b0, "sweep");
      chk("sweep_img", {2'b00, io_out[5:0]}, 8'(img[i]));
    end
    rd(4'd9, "rd9");
    chk("rd9_fill", io_out, 8'd60);

    // Load 45 (101101) into addr 3.
    cyc(4'd3, 1'b1, 1'b1, "ld3");
    chk("ld3_busy", {7'b0, io_out[6]}, 8'd1);
    for (int i = 4; i >= 0; i--) cyc(4'd3, 1'b1, 1'(6'd45 >> i), "ld3");
    chk("ld3_ack", {7'b0, io_out[7]}, 8'd1);
    chk("ld3_idle", {7'b0, io_out[6]}, 8'd0);
    cyc(4'd3, 1'b0, 1'b0, "ld3_post");
    chk("ld3_ack_pulse", {7'b0, io_out[7]}, 8'd0);
    chk("rd3_new", {2'b00, io_out[5:0]}, 8'd45);
    rd(4'd2, "rd2");
    chk("rd2_kept", io_out, 8'd4);

    // Abort after three bits at addr 5.
    for (int i = 0; i < 3; i++) cyc(4'd5, 1'b1, 1'b0, "abort");
    cyc(4'd5, 1'b0, 1'b0, "abort_drop");
    chk("abort_noack", {6'b0, io_out[7:6]}, 8'd0);
    rd(4'd5, "rd5");
    chk("rd5_kept", io_out, 8'd63);

    // Back-to-back words: 7 into addr 8 then 42 into addr 9, no gap.
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      logic [5:0] v;
      v = (i < 6) ? 6'd7 : 6'd42;
      cyc((i < 6) ? 4'd8 : 4'd9, 1'b1, v[5 - (i % 6)], "b2b");
      if (io_out[7]) acks++;
    end
    chk("b2b_acks", 8'(acks), 8'd2);
    rd(4'd8, "rd8");
    chk("rd8_new", io_out, 8'd7);
    rd(4'd9, "rd9b");
    chk("rd9_new", io_out, 8'd42);

    // Reset mid-load: four bits in, then a half-clock reset pulse.
    load_word(4'd3, 6'd45, "reld3");
    for (int i = 0; i < 4; i++) cyc(4'd1, 1'b1, 1'b1, "midload");
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async", io_out, 8'h00);
    #4;
    rst = 1'b0;
    le  = 1'b0;
    rd(4'd3, "rd3_rst");
    chk("rd3_default", io_out, 8'd0);
    rd(4'd8, "rd8_rst");
    chk("rd8_default", io_out, 8'd60);

    // Same-address read during commit at addr 6 with value 17.
    cyc(4'd6, 1'b0, 1'b0, "rdc_pre");
    load_word(4'd6, 6'd17, "rdc");
    chk("rdc_old", io_out, 8'h80 | 8'd3);
    cyc(4'd6, 1'b0, 1'b0, "rdc_next");
    chk("rdc_new", io_out, 8'd17);

    // Randomized traffic, mostly loading, against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), 1'($urandom), "rand");
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), "rand_dump");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
